// File: rtl/bri_sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bri_sw_pkg
//  Description : Shared types and constants for the bridge/dump ownership
//                arbiter: FSM state encoding, sequencer side constants and
//                the round-robin winner selection helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bri_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_OWN  = 2'd2
  } state_t;

  // Side encoding matches the mux select polarity: change=1 selects SEQ1
  localparam logic SIDE_SEQ1 = 1'b1;
  localparam logic SIDE_SEQ2 = 1'b0;

  // Lone requester wins; on a tie the side not currently selected wins
  function automatic logic rr_pick(input logic r1, input logic r2, input logic cur);
    if (r1 && r2) begin
      return ~cur;
    end else if (r1) begin
      return SIDE_SEQ1;
    end else begin
      return SIDE_SEQ2;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/bri_sw_dead_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bri_sw_dead_timer
//  Description : Loadable down-counter timing the blanking interval between
//                owners. Stops at zero; zero flag is high while idle at 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module bri_sw_dead_timer #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/bri_sw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bri_sw_arbiter
//  Description : Hands bridge/dump mux ownership between SEQ1 and SEQ2 with
//                a blanked dead-time on every owner change. All outputs are
//                registered. Optional hold watchdog enabled by defining
//                BRI_SW_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module bri_sw_arbiter
  import bri_sw_pkg::*;
#(
  parameter int DEAD_CYC = 16,
  parameter int CNT_W    = 16,
  parameter int WDOG_W   = 24,
  parameter int HOLD_MAX = 5000000
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             req1,
  input  logic             req2,
  output logic             grant1,
  output logic             grant2,
  output logic             change,
  output logic             blank,
  output logic [CNT_W-1:0] sw_cnt,
  output logic             fault,
  input  logic             fault_clr
);

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC - 1);

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             change_nxt;
  logic [CNT_W-1:0] sw_cnt_nxt;
  logic             grant_on;
  logic             dead_load;
  logic             dead_zero;
  logic             owner_req;
  logic             eff_req1, eff_req2;
  logic             win;
  logic             trip;
  logic             mask1, mask2;

  assign owner_req = (owner == SIDE_SEQ1) ? req1 : req2;
  assign eff_req1  = req1 & ~mask1;
  assign eff_req2  = req2 & ~mask2;
  assign win       = rr_pick(eff_req1, eff_req2, change);

  bri_sw_dead_timer #(
    .W (8)
  ) u_dead_timer (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (dead_load),
    .load_val (DEAD_LOAD),
    .zero     (dead_zero)
  );

  // Next-state, ownership and output decode; blanked with no grant by default
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    change_nxt = change;
    sw_cnt_nxt = sw_cnt;
    grant_on   = 1'b0;
    dead_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (eff_req1 || eff_req2) begin
          owner_nxt = win;
          if (win == change) begin
            state_nxt = ST_OWN;
            grant_on  = 1'b1;
          end else begin
            // Mux flips only here, while everything is still blanked
            change_nxt = ~change;
            sw_cnt_nxt = sw_cnt + CNT_W'(1);
            dead_load  = 1'b1;
            state_nxt  = ST_DEAD;
          end
        end
      end
      ST_DEAD: begin
        if (!owner_req) begin
          state_nxt = ST_IDLE;
        end else if (dead_zero) begin
          state_nxt = ST_OWN;
          grant_on  = 1'b1;
        end
      end
      ST_OWN: begin
        if (!owner_req || trip) begin
          state_nxt = ST_IDLE;
        end else begin
          grant_on = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      owner  <= SIDE_SEQ1;
      change <= 1'b1;
      grant1 <= 1'b0;
      grant2 <= 1'b0;
      blank  <= 1'b1;
      sw_cnt <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      change <= change_nxt;
      grant1 <= grant_on & (owner_nxt == SIDE_SEQ1);
      grant2 <= grant_on & (owner_nxt == SIDE_SEQ2);
      blank  <= ~grant_on;
      sw_cnt <= sw_cnt_nxt;
    end
  end

`ifdef BRI_SW_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;

  // Trip on the HOLD_MAX-th consecutive cycle of ownership
  assign trip = (state == ST_OWN) && owner_req &&
                (wdog_cnt == WDOG_W'(HOLD_MAX - 1));

  // Hold timer, sticky fault (trip beats clear) and per-side lockout
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      fault    <= 1'b0;
      mask1    <= 1'b0;
      mask2    <= 1'b0;
    end else begin
      wdog_cnt <= (state == ST_OWN) ? wdog_cnt + WDOG_W'(1) : '0;
      if (trip) begin
        fault <= 1'b1;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
      if (trip && (owner == SIDE_SEQ1)) begin
        mask1 <= 1'b1;
      end else if (!req1) begin
        mask1 <= 1'b0;
      end
      if (trip && (owner == SIDE_SEQ2)) begin
        mask2 <= 1'b1;
      end else if (!req2) begin
        mask2 <= 1'b0;
      end
    end
  end
`else
  logic [WDOG_W-1:0] unused_wdog;

  assign trip        = 1'b0;
  assign mask1       = 1'b0;
  assign mask2       = 1'b0;
  assign fault       = 1'b0;
  assign unused_wdog = WDOG_W'(HOLD_MAX) ^ {WDOG_W{fault_clr}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_bri_sw_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bri_sw_arbiter
//  Description : Directed bench for bri_sw_arbiter. Stimulus pushes
//                cycle-stamped expected output vectors into a scoreboard;
//                a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bri_sw_arbiter;

  localparam int DEAD_CYC = 16;
  localparam int CNT_W    = 16;
  localparam int HOLD_MAX = 100;

  logic             clk_sys   = 1'b0;
  logic             rst_n     = 1'b0;
  logic             req1      = 1'b0;
  logic             req2      = 1'b0;
  logic             fault_clr = 1'b0;
  logic             grant1, grant2, change, blank, fault;
  logic [CNT_W-1:0] sw_cnt;

  always #5 clk_sys = ~clk_sys;

  bri_sw_arbiter #(
    .DEAD_CYC (DEAD_CYC),
    .CNT_W    (CNT_W),
    .WDOG_W   (24),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .req1      (req1),
    .req2      (req2),
    .grant1    (grant1),
    .grant2    (grant2),
    .change    (change),
    .blank     (blank),
    .sw_cnt    (sw_cnt),
    .fault     (fault),
    .fault_clr (fault_clr)
  );

  // vec = {grant1, grant2, change, blank, fault, sw_cnt}
  typedef struct {
    int                 at;
    logic [8*12-1:0]    tag;
    logic [CNT_W+4:0]   vec;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   base;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic expect_at(input int at, input logic [8*12-1:0] tag,
                           input logic g1, input logic g2, input logic ch,
                           input logic bl, input logic [CNT_W-1:0] cnt,
                           input logic flt);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.vec = {g1, g2, ch, bl, flt, cnt};
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Monitor: compare every expectation due on this cycle
  always @(negedge clk_sys) begin
    logic [CNT_W+4:0] act;
    act = {grant1, grant2, change, blank, fault, sw_cnt};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        n_cmp++;
        if (sb[i].at < cyc) begin
          n_bad++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", sb[i].tag, sb[i].at, cyc);
        end else if (act !== sb[i].vec) begin
          n_bad++;
          $display("FAIL %s @%0d: got g1=%b g2=%b change=%b blank=%b fault=%b sw_cnt=%0d, expected g1=%b g2=%b change=%b blank=%b fault=%b sw_cnt=%0d",
                   sb[i].tag, cyc, act[CNT_W+4], act[CNT_W+3], act[CNT_W+2], act[CNT_W+1],
                   act[CNT_W], act[CNT_W-1:0],
                   sb[i].vec[CNT_W+4], sb[i].vec[CNT_W+3], sb[i].vec[CNT_W+2], sb[i].vec[CNT_W+1],
                   sb[i].vec[CNT_W], sb[i].vec[CNT_W-1:0]);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d checks pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    rst_n = 1'b0;
    step(3);
    expect_at(cyc, "reset", 0, 0, 1, 1, 0, 0);

    // SEQ1 alone, change already 1: grant next edge, no switch
    rst_n = 1'b1;
    req1  = 1'b1;
    base  = cyc;
    expect_at(base + 1, "own1", 1, 0, 1, 0, 0, 0);
    expect_at(base + 4, "own1_hold", 1, 0, 1, 0, 0, 0);
    step(4);
    req1 = 1'b0;
    base = cyc;
    expect_at(base + 1, "rel1", 0, 0, 1, 1, 0, 0);
    step(1);

    // SEQ2 alone: switch, 16 blanked cycles, grant2 on the 17th edge
    req2 = 1'b1;
    base = cyc;
    expect_at(base + 1, "dead2", 0, 0, 0, 1, 1, 0);
    for (int k = 2; k <= 16; k++) expect_at(base + k, "blank2", 0, 0, 0, 1, 1, 0);
    expect_at(base + 17, "own2", 0, 1, 0, 0, 1, 0);
    step(18);
    req2 = 1'b0;
    step(1);
    expect_at(cyc, "rel2", 0, 0, 0, 1, 1, 0);

    // Both with change=0: SEQ1 wins; SEQ2 held high is not allowed to preempt
    req1 = 1'b1;
    req2 = 1'b1;
    base = cyc;
    expect_at(base + 1, "rr_to_s1", 0, 0, 1, 1, 2, 0);
    expect_at(base + 10, "rr_dead1", 0, 0, 1, 1, 2, 0);
    expect_at(base + 17, "rr_own1", 1, 0, 1, 0, 2, 0);
    expect_at(base + 22, "no_preempt", 1, 0, 1, 0, 2, 0);
    step(22);

    // Both with change=1: SEQ2 wins
    req1 = 1'b0;
    step(1);
    expect_at(cyc, "rel1b", 0, 0, 1, 1, 2, 0);
    req1 = 1'b1;
    base = cyc;
    expect_at(base + 1, "rr_to_s2", 0, 0, 0, 1, 3, 0);
    expect_at(base + 17, "rr_own2", 0, 1, 0, 0, 3, 0);
    step(18);
    req1 = 1'b0;
    req2 = 1'b0;
    step(1);
    expect_at(cyc, "rel_both", 0, 0, 0, 1, 3, 0);

    // Reset from idle, then abort a switch at DEAD cycle 5
    rst_n = 1'b0;
    step(1);
    expect_at(cyc, "reset2", 0, 0, 1, 1, 0, 0);
    rst_n = 1'b1;
    req2  = 1'b1;
    base  = cyc;
    expect_at(base + 1, "ab_dead", 0, 0, 0, 1, 1, 0);
    expect_at(base + 5, "ab_dead5", 0, 0, 0, 1, 1, 0);
    step(5);
    req2 = 1'b0;
    expect_at(base + 6, "ab_idle", 0, 0, 0, 1, 1, 0);
    expect_at(base + 17, "ab_nogrant", 0, 0, 0, 1, 1, 0);
    expect_at(base + 25, "ab_stay", 0, 0, 0, 1, 1, 0);
    step(20);

    // change is now 0: SEQ2 gets the bridge directly, then reset mid-OWN
    req2 = 1'b1;
    base = cyc;
    expect_at(base + 1, "own2_direct", 0, 1, 0, 0, 1, 0);
    step(3);
    rst_n = 1'b0;
    expect_at(cyc + 1, "rst_mid_own", 0, 0, 1, 1, 0, 0);
    step(1);
    rst_n = 1'b1;
    req2  = 1'b0;
    step(2);
    expect_at(cyc, "post_rst", 0, 0, 1, 1, 0, 0);

`ifdef BRI_SW_WDOG_EN
    // Hold SEQ1 past HOLD_MAX: revoke, fault, lockout until req1 drops
    req1 = 1'b1;
    base = cyc;
    expect_at(base + 1, "wd_own", 1, 0, 1, 0, 0, 0);
    expect_at(base + HOLD_MAX, "wd_last", 1, 0, 1, 0, 0, 0);
    expect_at(base + HOLD_MAX + 1, "wd_trip", 0, 0, 1, 1, 0, 1);
    expect_at(base + 150, "wd_masked", 0, 0, 1, 1, 0, 1);
    step(150);
    fault_clr = 1'b1;
    expect_at(cyc + 1, "wd_clr", 0, 0, 1, 1, 0, 0);
    step(1);
    fault_clr = 1'b0;
    expect_at(cyc + 40, "wd_still_mask", 0, 0, 1, 1, 0, 0);
    step(49);
    req1 = 1'b0;
    step(1);
    req1 = 1'b1;
    expect_at(cyc + 1, "wd_unmask", 1, 0, 1, 0, 0, 0);
    step(2);
    req1 = 1'b0;
    step(2);
`endif

    step(3);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: check for cycle %0d never reached", e.tag, e.at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
